// File: rtl/decode_scoreboard_pkg.sv
// Shared decode definitions: opcode constants, field positions and scoreboard state encoding.
// The decoder stage and the issue scoreboard both import this package.
package decode_scoreboard_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;
  // Every 001xxx opcode is an immediate ALU op writing rt.
  localparam logic [2:0]              OP_IMM_PREFIX = 3'b001;

  typedef enum logic {
    SB_EMPTY = 1'b0,
    SB_FULL  = 1'b1
  } sb_state_t;

endpackage

// File: rtl/decode_scoreboard_field_decode.sv
// Combinational instruction classifier: which source fields are read and which
// register (if any) is written. A write to register 0 is dropped here.
module sb_field_decode
  import decode_scoreboard_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int IWIDTH = 32
) (
  input  logic [IWIDTH-1:0] instr,
  output logic              use_rs,
  output logic              use_rt,
  output logic [AWIDTH-1:0] rs,
  output logic [AWIDTH-1:0] rt,
  output logic [AWIDTH-1:0] dst,
  output logic              reg_wr,
  output logic              reg_dst
);

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [AWIDTH-1:0]       rd;
  logic                    wr_raw;
  logic                    unused_low;

  assign opcode     = instr[OPCODE_LSB +: OPCODE_WIDTH];
  assign rs         = instr[RS_LSB +: AWIDTH];
  assign rt         = instr[RT_LSB +: AWIDTH];
  assign rd         = instr[RD_LSB +: AWIDTH];
  assign unused_low = ^instr[RD_LSB-1:0];

  always_comb begin
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    dst     = '0;
    wr_raw  = 1'b0;
    reg_dst = 1'b0;
    if (opcode == OP_RTYPE) begin
      use_rs  = 1'b1;
      use_rt  = 1'b1;
      dst     = rd;
      wr_raw  = 1'b1;
      reg_dst = 1'b1;
    end else if (opcode[5:3] == OP_IMM_PREFIX || opcode == OP_LW) begin
      use_rs = 1'b1;
      dst    = rt;
      wr_raw = 1'b1;
    end else if (opcode == OP_SW || opcode == OP_BEQ || opcode == OP_BNE) begin
      use_rs = 1'b1;
      use_rt = 1'b1;
    end
    // OP_J and unknown opcodes fall through as no-ops with no operands.
    reg_wr = wr_raw && (dst != '0);
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Single-entry issue scoreboard: holds one fetched instruction, stalls it while any
// operand register is busy, and issues it registered to the decoder stage.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int IWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic                     sb_clk,
  input  logic                     sb_rst,
  input  logic                     sb_i_valid,
  input  logic [IWIDTH-1:0]        sb_i_instr,
  output logic                     sb_o_ready,
  input  logic                     sb_i_wb_valid,
  input  logic [AWIDTH-1:0]        sb_i_wb_addr,
  input  logic                     sb_i_flush,
  output logic                     sb_o_ce,
  output logic [IWIDTH-1:0]        sb_o_instr,
  output logic                     sb_o_reg_wr,
  output logic                     sb_o_reg_dst,
  output logic [CWIDTH-1:0]        sb_o_stall_cnt,
  output logic                     sb_o_dbg_state,
  output logic [(1<<AWIDTH)-1:0]   sb_o_dbg_busy
);

  localparam int NREGS = 1 << AWIDTH;

  sb_state_t         state, state_n;
  logic [IWIDTH-1:0] hold_q;
  logic [NREGS-1:0]  busy_q, wb_clr, busy_eff, busy_set;
  logic              use_rs, use_rt, reg_wr, reg_dst;
  logic [AWIDTH-1:0] rs, rt, dst;
  logic              hazard, issue, accept, stall;

  sb_field_decode #(.AWIDTH(AWIDTH), .IWIDTH(IWIDTH)) u_field_decode (
    .instr   (hold_q),
    .use_rs  (use_rs),
    .use_rt  (use_rt),
    .rs      (rs),
    .rt      (rt),
    .dst     (dst),
    .reg_wr  (reg_wr),
    .reg_dst (reg_dst)
  );

  // Same-cycle writeback clears before the hazard check, so a retiring write bypasses.
  always_comb begin
    wb_clr = '0;
    if (sb_i_wb_valid) wb_clr[sb_i_wb_addr] = 1'b1;
    busy_eff = busy_q & ~wb_clr;
    hazard = (use_rs && rs != '0 && busy_eff[rs]) ||
             (use_rt && rt != '0 && busy_eff[rt]) ||
             (reg_wr && busy_eff[dst]);
    busy_set = '0;
    if (issue && reg_wr) busy_set[dst] = 1'b1;
  end

  always_ff @(posedge sb_clk or negedge sb_rst) begin
    if (!sb_rst) state <= SB_EMPTY;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (sb_i_flush)  state_n = SB_EMPTY;
    else if (accept) state_n = SB_FULL;
    else if (issue)  state_n = SB_EMPTY;
  end

  // Handshake: an instruction transfers on a rising edge where sb_i_valid and
  // sb_o_ready are both high; sb_o_ready never depends on sb_i_valid, and flush
  // forces it low so nothing is accepted in a flush cycle.
  always_comb begin
    issue      = (state == SB_FULL) && !hazard && !sb_i_flush;
    stall      = (state == SB_FULL) && hazard;
    sb_o_ready = !sb_i_flush && ((state == SB_EMPTY) || issue);
    accept     = sb_i_valid && sb_o_ready;
  end

  always_ff @(posedge sb_clk or negedge sb_rst) begin
    if (!sb_rst) begin
      hold_q         <= '0;
      busy_q         <= '0;
      sb_o_ce        <= 1'b0;
      sb_o_instr     <= '0;
      sb_o_reg_wr    <= 1'b0;
      sb_o_reg_dst   <= 1'b0;
      sb_o_stall_cnt <= '0;
    end else begin
      // OR-ing the set after the clear lets a same-register set win.
      busy_q  <= busy_eff | busy_set;
      sb_o_ce <= issue;
      if (accept) hold_q <= sb_i_instr;
      if (issue) begin
        sb_o_instr   <= hold_q;
        sb_o_reg_wr  <= reg_wr;
        sb_o_reg_dst <= reg_dst;
      end
      if (stall && sb_o_stall_cnt != '1) sb_o_stall_cnt <= sb_o_stall_cnt + CWIDTH'(1);
    end
  end

  assign sb_o_dbg_state = state;
  assign sb_o_dbg_busy  = busy_q;

endmodule
